pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives the enable/flush pair of every
//  pipeline register (if_id, id_ex, ex_mem, mem_wb) plus the PC write enable. Resolves cache waits,
//  load-use hazards, taken branches/jumps and halt drain in a fixed priority. Keeps saturating perf counters.
// PARAMETERS
//  REG_W  5   register-index width
//  CNT_W  32  perf-counter width
// PORTS
//  CLK              in   1      clock, rising edge
//  RST              in   1      synchronous reset, active-high
//  ihit             in   1      icache returned instruction this cycle
//  dhit             in   1      dcache completed MEM-stage access this cycle
//  mem_dreq         in   1      MEM-stage instr issues dmemREN|dmemWEN
//  ex_memread       in   1      EX-stage instr is a load
//  ex_rt            in   REG_W  EX-stage load destination
//  id_rs, id_rt     in   REG_W  ID-stage source indices
//  id_uses_rt       in   1      ID-stage instr reads rt
//  ex_branch_taken  in   1      EX resolved taken branch/jump (PC redirect)
//  mem_halt         in   1      halt instr in MEM stage
//  wb_halt          in   1      halt instr at mem_wb output
//  pc_en            out  1      PC write enable
//  if_id_en/_flush  out  1/1    IF/ID enable, flush (flush honoured only with en)
//  id_ex_en/_flush  out  1/1    ID/EX enable, flush
//  ex_mem_en/_flush out  1/1    EX/MEM enable, flush
//  mem_wb_en/_flush out  1/1    MEM/WB enable, flush
//  halt             out  1      registered, sticky processor-halted flag
//  cyc_cnt          out  CNT_W  cycles spent outside HALTED
//  stall_cnt        out  CNT_W  non-HALTED cycles with pc_en=0
//  flush_cnt        out  CNT_W  taken-branch flush events
// BEHAVIOUR
//  Reset (RST high at edge): state=RUN, halt=0, all counters 0. Single clock, sync reset only.
//  FSM: RUN -> DRAIN when mem_halt & ~dwait; DRAIN -> HALTED when wb_halt; HALTED sticky until RST.
//    RUN -> HALTED directly if wb_halt is seen in RUN.
//  Terms: dwait = mem_dreq & ~dhit; load_use = ex_memread & ex_rt!=0 &
//    (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
//  Outputs combinational from state+inputs; priority (first match wins), RUN state:
//   1 dwait: pc_en=0; if_id/id_ex/ex_mem en=0; mem_wb_en=1 mem_wb_flush=1 (bubble to WB).
//   2 ex_branch_taken: pc_en=1; if_id en+flush; id_ex en+flush; ex_mem_en=1; mem_wb_en=1.
//     Redirect proceeds regardless of ihit.
//   3 load_use: pc_en=0; if_id_en=0; id_ex en+flush; ex_mem_en=1; mem_wb_en=1.
//   4 ~ihit: pc_en=0; if_id en+flush; id_ex/ex_mem/mem_wb en=1.
//   5 else: all en=1, all flush=0.
//  DRAIN: pc_en=0; if_id en+flush; id_ex en+flush; ex_mem_en=1; mem_wb_en=1; dwait still wins (rule 1);
//    branch, load_use and ihit ignored.
//  HALTED: all en=0, all flush=0, pc_en=0; halt=1 registered (asserted the cycle after entry edge).
//  Flush outputs are 0 whenever the matching en is 0.
//  Counters: update on each edge while state!=HALTED; cyc_cnt +1; stall_cnt +1 if pc_en=0;
//   flush_cnt +1 if rule 2 applied. All saturate at 2^CNT_W-1 (no wrap). Frozen in HALTED.
//  RST mid-stall or mid-drain: next cycle is RUN with counters 0, no state carried.
// TESTING
//  T1 reset: RST=1 two cycles, ihit=1 -> all en=1, flush=0, halt=0, counters 0 after release.
//  T2 load-use: ex_memread=1, ex_rt=5, id_rs=5, ihit=1 -> pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt+1.
//  T3 dwait+branch same cycle: mem_dreq=1, dhit=0, ex_branch_taken=1 -> rule 1 only, flush_cnt unchanged;
//     next cycle dhit=1 -> branch flush (if_id_flush=id_ex_flush=1), flush_cnt=1.
//  T4 ex_rt=0 load-use: ex_memread=1, ex_rt=0, id_rs=0 -> no stall.
//  T5 halt: mem_halt=1 -> DRAIN 1 cycle (pc_en=0); wb_halt=1 -> halt=1 next cycle, all en=0, counters frozen.
//  T6 saturation: CNT_W=4, 20 cycles ihit=0 -> stall_cnt=15, cyc_cnt=15; RST -> 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (PC plus four pipeline registers).
// Latency: enable/flush outputs are combinational from state+inputs; halt and counters are registered.
// Backpressure: a dcache wait freezes IF..EX and bubbles WB; an icache miss holds the PC and bubbles ID.
//
// Ports:
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   ihit, dhit, mem_dreq     cache handshake: instr fetched, MEM access done, MEM access pending
//   ex_memread, ex_rt        EX-stage load and its destination register
//   id_rs, id_rt, id_uses_rt ID-stage source registers and whether rt is read
//   ex_branch_taken          EX-stage PC redirect
//   mem_halt, wb_halt        halt instruction in MEM / at the mem_wb output
//   pc_en, *_en, *_flush     PC write enable and per-register enable/flush pairs
//   halt                     sticky processor-halted flag
//   cyc_cnt, stall_cnt,      saturating perf counters: active cycles, cycles with the PC held,
//   flush_cnt                taken-branch flush events
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dreq,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_halt,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             ex_mem_flush,
  output logic             mem_wb_en,
  output logic             mem_wb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             halt_q;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic dwait;
  logic load_use;
  logic branch_flush;

  // A pending MEM access that has not completed holds everything upstream of MEM.
  assign dwait = mem_dreq & ~dhit;

  // Register 0 is hardwired, so a load targeting it never creates a real dependency.
  assign load_use = ex_memread && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_ONE;
  endfunction

  // Next state and stage controls. Priority inside RUN: dwait, branch, load-use, icache miss.
  always_comb begin
    state_d      = state_q;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_en    = 1'b0;
    mem_wb_flush = 1'b0;
    branch_flush = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (wb_halt) begin
          state_d = ST_HALTED;
        end else if (mem_halt && !dwait) begin
          state_d = ST_DRAIN;
        end

        if (dwait) begin
          mem_wb_en    = 1'b1;
          mem_wb_flush = 1'b1;
        end else if (ex_branch_taken) begin
          // Redirect goes ahead even on an icache miss; the wrong-path slots are squashed.
          pc_en        = 1'b1;
          if_id_en     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_en     = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_en    = 1'b1;
          mem_wb_en    = 1'b1;
          branch_flush = 1'b1;
        end else if (load_use) begin
          id_ex_en     = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_en    = 1'b1;
          mem_wb_en    = 1'b1;
        end else if (!ihit) begin
          if_id_en     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_en     = 1'b1;
          ex_mem_en    = 1'b1;
          mem_wb_en    = 1'b1;
        end else begin
          pc_en        = 1'b1;
          if_id_en     = 1'b1;
          id_ex_en     = 1'b1;
          ex_mem_en    = 1'b1;
          mem_wb_en    = 1'b1;
        end
      end

      ST_DRAIN: begin
        if (wb_halt) begin
          state_d = ST_HALTED;
        end

        // Nothing new enters the pipe; the halt and older instructions drain towards WB.
        if (dwait) begin
          mem_wb_en    = 1'b1;
          mem_wb_flush = 1'b1;
        end else begin
          if_id_en     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_en     = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_en    = 1'b1;
          mem_wb_en    = 1'b1;
        end
      end

      default: begin
        state_d = ST_HALTED;
      end
    endcase
  end

  // Perf counters advance on every edge taken outside HALTED, saturating at all-ones.
  always_comb begin
    cyc_d   = cyc_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if (state_q != ST_HALTED) begin
      cyc_d = sat_inc(cyc_q);
      if (!pc_en) begin
        stall_d = sat_inc(stall_q);
      end
      if (branch_flush) begin
        flush_d = sat_inc(flush_q);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
      halt_q  <= 1'b0;
      cyc_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= (state_d == ST_HALTED);
      cyc_q   <= cyc_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign halt      = halt_q;
  assign cyc_cnt   = cyc_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a 32-bit-counter instance and a 4-bit-counter instance share
// all inputs, and every cycle both are compared with a rule-table reference model.
module tb_pipeline_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ihit = 1'b0, dhit = 1'b0, mem_dreq = 1'b0, ex_memread = 1'b0;
  logic [4:0] ex_rt = '0, id_rs = '0, id_rt = '0;
  logic       id_uses_rt = 1'b0, ex_branch_taken = 1'b0, mem_halt = 1'b0, wb_halt = 1'b0;

  logic        pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic        ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush, halt;
  logic [31:0] cyc_cnt, stall_cnt, flush_cnt;

  logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush;
  logic        s_ex_mem_en, s_ex_mem_flush, s_mem_wb_en, s_mem_wb_flush, s_halt;
  logic [3:0]  s_cyc_cnt, s_stall_cnt, s_flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(32)) u_dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_branch_taken(ex_branch_taken),
    .mem_halt(mem_halt), .wb_halt(wb_halt),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush),
    .mem_wb_en(mem_wb_en), .mem_wb_flush(mem_wb_flush), .halt(halt),
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.REG_W(5), .CNT_W(4)) u_sat (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_branch_taken(ex_branch_taken),
    .mem_halt(mem_halt), .wb_halt(wb_halt),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush),
    .id_ex_en(s_id_ex_en), .id_ex_flush(s_id_ex_flush),
    .ex_mem_en(s_ex_mem_en), .ex_mem_flush(s_ex_mem_flush),
    .mem_wb_en(s_mem_wb_en), .mem_wb_flush(s_mem_wb_flush), .halt(s_halt),
    .cyc_cnt(s_cyc_cnt), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // Reference model: mode 0=running, 1=draining, 2=halted; unbounded event counts.
  int     m_mode  = 0;
  logic   m_valid = 1'b0;
  longint m_cyc = 0, m_stall = 0, m_flush = 0;

  // Which behaviour rule applies this cycle: 0 halted, 1 dwait, 2 branch, 3 load-use,
  // 4 icache miss, 5 normal flow, 6 drain.
  function automatic int model_rule();
    logic dw, lu;
    dw = mem_dreq && !dhit;
    lu = ex_memread && (ex_rt != 0) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    if (m_mode == 2) return 0;
    if (dw) return 1;
    if (m_mode == 1) return 6;
    if (ex_branch_taken) return 2;
    if (lu) return 3;
    if (!ihit) return 4;
    return 5;
  endfunction

  // {pc_en, if_id en/flush, id_ex en/flush, ex_mem en/flush, mem_wb en/flush}
  function automatic logic [8:0] rule_ctrl(input int r);
    case (r)
      1:       return 9'b0_00_00_00_11;
      2:       return 9'b1_11_11_10_10;
      3:       return 9'b0_00_11_10_10;
      4:       return 9'b0_11_10_10_10;
      5:       return 9'b1_10_10_10_10;
      6:       return 9'b0_11_11_10_10;
      default: return 9'b0_00_00_00_00;
    endcase
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // One clock: compare at the falling edge, then advance the model to the rising edge.
  task automatic tick(input bit chk);
    int         r;
    logic [8:0] exp_c, got_c, got_s;
    @(negedge CLK);
    r     = model_rule();
    exp_c = rule_ctrl(r);
    if (chk && m_valid) begin
      got_c = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, ex_mem_flush, mem_wb_en, mem_wb_flush};
      got_s = {s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_flush,
               s_ex_mem_en, s_ex_mem_flush, s_mem_wb_en, s_mem_wb_flush};
      n_cmp++;
      if (got_c !== exp_c) begin
        n_err++;
        $display("FAIL ctrl t=%0t rule=%0d got %b want %b", $time, r, got_c, exp_c);
      end
      n_cmp++;
      if (got_s !== exp_c) begin
        n_err++;
        $display("FAIL ctrl_w4 t=%0t rule=%0d got %b want %b", $time, r, got_s, exp_c);
      end
      n_cmp++;
      if ({halt, s_halt} !== {2{m_mode == 2}}) begin
        n_err++;
        $display("FAIL halt t=%0t got %b/%b want %b", $time, halt, s_halt, m_mode == 2);
      end
      n_cmp++;
      if ({cyc_cnt, stall_cnt, flush_cnt} !==
          {32'(sat(m_cyc, 32)), 32'(sat(m_stall, 32)), 32'(sat(m_flush, 32))}) begin
        n_err++;
        $display("FAIL counters t=%0t got %0d/%0d/%0d want %0d/%0d/%0d", $time,
                 cyc_cnt, stall_cnt, flush_cnt, m_cyc, m_stall, m_flush);
      end
      n_cmp++;
      if ({s_cyc_cnt, s_stall_cnt, s_flush_cnt} !==
          {4'(sat(m_cyc, 4)), 4'(sat(m_stall, 4)), 4'(sat(m_flush, 4))}) begin
        n_err++;
        $display("FAIL counters_w4 t=%0t got %0d/%0d/%0d want %0d/%0d/%0d", $time,
                 s_cyc_cnt, s_stall_cnt, s_flush_cnt,
                 sat(m_cyc, 4), sat(m_stall, 4), sat(m_flush, 4));
      end
    end
    if (RST) begin
      m_mode = 0; m_cyc = 0; m_stall = 0; m_flush = 0; m_valid = 1'b1;
    end else if (m_valid && m_mode != 2) begin
      m_cyc++;
      if (!exp_c[8]) m_stall++;
      if (r == 2) m_flush++;
      if (wb_halt) m_mode = 2;
      else if (m_mode == 0 && mem_halt && !(mem_dreq && !dhit)) m_mode = 1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; mem_dreq = 1'b0; ex_memread = 1'b0;
    ex_rt = '0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    ex_branch_taken = 1'b0; mem_halt = 1'b0; wb_halt = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick(1'b1);
    tick(1'b1);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b1;
    tick(1'b0);
    tick(1'b1);
    RST = 1'b0;
    tick(1'b1);
    tick(1'b1);
  endtask

  task automatic test_load_use();
    idle_inputs();
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    tick(1'b1);
    id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b1;
    tick(1'b1);
    id_uses_rt = 1'b0;
    tick(1'b1);
    idle_inputs();
    tick(1'b1);
  endtask

  task automatic test_dwait_branch();
    idle_inputs();
    mem_dreq = 1'b1; dhit = 1'b0; ex_branch_taken = 1'b1;
    tick(1'b1);
    dhit = 1'b1;
    tick(1'b1);
    idle_inputs();
    tick(1'b1);
  endtask

  task automatic test_zero_rt();
    idle_inputs();
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rt = 1'b1;
    tick(1'b1);
    ihit = 1'b0;
    tick(1'b1);
    idle_inputs();
    tick(1'b1);
  endtask

  task automatic test_halt();
    idle_inputs();
    mem_halt = 1'b1;
    tick(1'b1);
    mem_halt = 1'b0; ex_branch_taken = 1'b1;
    tick(1'b1);
    ex_branch_taken = 1'b0; wb_halt = 1'b1;
    tick(1'b1);
    wb_halt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ihit = 1'($urandom); ex_branch_taken = 1'($urandom); mem_dreq = 1'($urandom);
      tick(1'b1);
    end
    idle_inputs();
    do_reset();
    tick(1'b1);
  endtask

  task automatic test_saturation();
    idle_inputs();
    do_reset();
    ihit = 1'b0;
    for (int i = 0; i < 20; i++) tick(1'b1);
    n_cmp++;
    if (s_stall_cnt !== 4'd15 || s_cyc_cnt !== 4'd15) begin
      n_err++;
      $display("FAIL saturation got stall=%0d cyc=%0d want 15/15", s_stall_cnt, s_cyc_cnt);
    end
    RST = 1'b1;
    tick(1'b1);
    RST = 1'b0;
    idle_inputs();
    tick(1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      RST             = ($urandom_range(0, 99) < 2);
      ihit            = ($urandom_range(0, 3) != 0);
      mem_dreq        = 1'($urandom);
      dhit            = 1'($urandom);
      ex_memread      = 1'($urandom);
      ex_rt           = 5'($urandom_range(0, 3));
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      id_uses_rt      = 1'($urandom);
      ex_branch_taken = ($urandom_range(0, 3) == 0);
      mem_halt        = ($urandom_range(0, 19) == 0);
      wb_halt         = ($urandom_range(0, 29) == 0);
      tick(1'b1);
    end
    idle_inputs();
    do_reset();
    tick(1'b1);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_dwait_branch();
    test_zero_rt();
    test_halt();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
